// File: rtl/peripheral_bus_arbiter.sv
// Two-master round-robin arbiter for the byte-wide peripheral bus.
// Each grant becomes one registered single-cycle bus transaction plus a one-cycle ack.
module peripheral_bus_arbiter #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic                  m0_write,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic                  m1_write,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] bus_address,
  output logic                  bus_write_en,
  output logic [DATA_WIDTH-1:0] bus_data_out,
  input  logic [DATA_WIDTH-1:0] bus_data_in
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_last_grant;
  logic                  w_last_grant_nxt;
  logic                  r_grant;
  logic                  w_grant_nxt;
  logic                  w_pick;
  logic [ADDR_WIDTH-1:0] r_bus_address;
  logic [ADDR_WIDTH-1:0] w_bus_address_nxt;
  logic                  r_bus_write_en;
  logic                  w_bus_write_en_nxt;
  logic [DATA_WIDTH-1:0] r_bus_data_out;
  logic [DATA_WIDTH-1:0] w_bus_data_out_nxt;
  logic                  r_m0_ack;
  logic                  w_m0_ack_nxt;
  logic                  r_m1_ack;
  logic                  w_m1_ack_nxt;
  logic [DATA_WIDTH-1:0] r_m0_rdata;
  logic [DATA_WIDTH-1:0] w_m0_rdata_nxt;
  logic [DATA_WIDTH-1:0] r_m1_rdata;
  logic [DATA_WIDTH-1:0] w_m1_rdata_nxt;

  // On a tie the master that did not win last time gets the bus.
  assign w_pick = (m0_req && m1_req) ? ~r_last_grant : m1_req;

  always_comb begin
    w_state_nxt        = r_state;
    w_last_grant_nxt   = r_last_grant;
    w_grant_nxt        = r_grant;
    w_bus_address_nxt  = r_bus_address;
    w_bus_write_en_nxt = 1'b0;
    w_bus_data_out_nxt = r_bus_data_out;
    w_m0_ack_nxt       = 1'b0;
    w_m1_ack_nxt       = 1'b0;
    w_m0_rdata_nxt     = r_m0_rdata;
    w_m1_rdata_nxt     = r_m1_rdata;
    unique case (r_state)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          w_grant_nxt      = w_pick;
          w_last_grant_nxt = w_pick;
          if (w_pick) begin
            w_bus_address_nxt  = m1_addr;
            w_bus_write_en_nxt = m1_write;
            w_bus_data_out_nxt = m1_wdata;
          end else begin
            w_bus_address_nxt  = m0_addr;
            w_bus_write_en_nxt = m0_write;
            w_bus_data_out_nxt = m0_wdata;
          end
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Read data is captured on writes too; masters simply ignore it then.
        if (r_grant) begin
          w_m1_rdata_nxt = bus_data_in;
          w_m1_ack_nxt   = 1'b1;
        end else begin
          w_m0_rdata_nxt = bus_data_in;
          w_m0_ack_nxt   = 1'b1;
        end
        w_state_nxt = S_ACK;
      end
      S_ACK: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_last_grant   <= 1'b1;
      r_grant        <= 1'b0;
      r_bus_address  <= '0;
      r_bus_write_en <= 1'b0;
      r_bus_data_out <= '0;
      r_m0_ack       <= 1'b0;
      r_m1_ack       <= 1'b0;
      r_m0_rdata     <= '0;
      r_m1_rdata     <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_last_grant   <= w_last_grant_nxt;
      r_grant        <= w_grant_nxt;
      r_bus_address  <= w_bus_address_nxt;
      r_bus_write_en <= w_bus_write_en_nxt;
      r_bus_data_out <= w_bus_data_out_nxt;
      r_m0_ack       <= w_m0_ack_nxt;
      r_m1_ack       <= w_m1_ack_nxt;
      r_m0_rdata     <= w_m0_rdata_nxt;
      r_m1_rdata     <= w_m1_rdata_nxt;
    end
  end

  assign bus_address  = r_bus_address;
  assign bus_write_en = r_bus_write_en;
  assign bus_data_out = r_bus_data_out;
  assign m0_ack       = r_m0_ack;
  assign m1_ack       = r_m1_ack;
  assign m0_rdata     = r_m0_rdata;
  assign m1_rdata     = r_m1_rdata;

endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// Directed bench for peripheral_bus_arbiter with an LED-panel register at 0x5c00.
module tb_peripheral_bus_arbiter;

  logic        clock;
  logic        reset;
  logic        m0_req;
  logic [18:0] m0_addr;
  logic        m0_write;
  logic [7:0]  m0_wdata;
  logic        m0_ack;
  logic [7:0]  m0_rdata;
  logic        m1_req;
  logic [18:0] m1_addr;
  logic        m1_write;
  logic [7:0]  m1_wdata;
  logic        m1_ack;
  logic [7:0]  m1_rdata;
  logic [18:0] bus_address;
  logic        bus_write_en;
  logic [7:0]  bus_data_out;
  logic [7:0]  bus_data_in;
  logic [7:0]  leds;

  int errors;
  int checks;

  peripheral_bus_arbiter #(.ADDR_WIDTH(19), .DATA_WIDTH(8)) dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_write(m0_write), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_write(m1_write), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .bus_address(bus_address), .bus_write_en(bus_write_en),
    .bus_data_out(bus_data_out), .bus_data_in(bus_data_in)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // LED panel register at 0x5c00; every other address reads back addr[7:0] ^ 0xA5.
  always @(posedge clock) begin
    if (bus_write_en && bus_address == 19'h05c00) leds <= bus_data_out;
  end
  assign bus_data_in = (bus_address == 19'h05c00) ? leds : (bus_address[7:0] ^ 8'hA5);

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (bus_address !== 19'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", bus_address); end
    checks++; if (bus_write_en !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", bus_write_en); end
    checks++; if (bus_data_out !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", bus_data_out); end
    checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b%b exp=00", m0_ack, m1_ack); end
    checks++; if (m0_rdata !== 8'h00 || m1_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got=%h/%h exp=00/00", m0_rdata, m1_rdata); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_m0_write();
    m0_addr = 19'h05c00; m0_write = 1'b1; m0_wdata = 8'h5A; m0_req = 1'b1;
    tick();
    checks++; if (bus_write_en !== 1'b1) begin errors++; $display("FAIL wr_issue_we got=%b exp=1", bus_write_en); end
    checks++; if (bus_address !== 19'h05c00) begin errors++; $display("FAIL wr_issue_addr got=%h exp=05c00", bus_address); end
    checks++; if (bus_data_out !== 8'h5A) begin errors++; $display("FAIL wr_issue_dout got=%h exp=5a", bus_data_out); end
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL wr_issue_ack got=%b exp=0", m0_ack); end
    tick();
    checks++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin errors++; $display("FAIL wr_ack got=%b%b exp=10", m0_ack, m1_ack); end
    checks++; if (bus_write_en !== 1'b0) begin errors++; $display("FAIL wr_ack_we got=%b exp=0", bus_write_en); end
    checks++; if (leds !== 8'h5A) begin errors++; $display("FAIL wr_leds got=%h exp=5a", leds); end
    m0_req = 1'b0;
    tick();
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_one_cycle got=%b exp=0", m0_ack); end
    checks++; if (bus_address !== 19'h05c00 || bus_data_out !== 8'h5A) begin errors++; $display("FAIL wr_hold got=%h/%h exp=05c00/5a", bus_address, bus_data_out); end
  endtask

  task automatic test_m1_read();
    m1_addr = 19'h01066; m1_write = 1'b0; m1_wdata = 8'h77; m1_req = 1'b1;
    tick();
    checks++; if (bus_write_en !== 1'b0) begin errors++; $display("FAIL rd_issue_we got=%b exp=0", bus_write_en); end
    checks++; if (bus_address !== 19'h01066) begin errors++; $display("FAIL rd_issue_addr got=%h exp=01066", bus_address); end
    tick();
    checks++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin errors++; $display("FAIL rd_ack got=m0:%b m1:%b exp=m0:0 m1:1", m0_ack, m1_ack); end
    checks++; if (m1_rdata !== 8'hC3) begin errors++; $display("FAIL rd_rdata got=%h exp=c3", m1_rdata); end
    // m0's earlier write captured the panel value from before the write landed.
    checks++; if (m0_rdata !== 8'h3C) begin errors++; $display("FAIL rd_m0_rdata_kept got=%h exp=3c", m0_rdata); end
    m1_req = 1'b0;
    tick();
    checks++; if (m1_ack !== 1'b0 || m1_rdata !== 8'hC3) begin errors++; $display("FAIL rd_after got=%b/%h exp=0/c3", m1_ack, m1_rdata); end
  endtask

  task automatic test_arbitration();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m0_addr = 19'h00010; m0_write = 1'b0; m0_req = 1'b1;
    m1_addr = 19'h00020; m1_write = 1'b0; m1_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (bus_address !== ((k % 2 == 0) ? 19'h00010 : 19'h00020)) begin
        errors++; $display("FAIL arb_grant%0d got_addr=%h exp_master=%0d", k, bus_address, k % 2);
      end
      tick();
      checks++;
      if (m0_ack !== (k % 2 == 0) || m1_ack !== (k % 2 == 1)) begin
        errors++; $display("FAIL arb_ack%0d got=m0:%b m1:%b exp_master=%0d", k, m0_ack, m1_ack, k % 2);
      end
      tick();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    checks++; if (m0_rdata !== 8'hB5 || m1_rdata !== 8'h85) begin errors++; $display("FAIL arb_rdata got=%h/%h exp=b5/85", m0_rdata, m1_rdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    n = 0;
    m1_addr = 19'h00020; m1_req = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (m0_ack) begin errors++; checks++; $display("FAIL b2b_m0_ack cycle=%0d got=1 exp=0", c); end
      if (m1_ack) begin
        checks++;
        if (c != 2 + 3 * n) begin errors++; $display("FAIL b2b_spacing got_cycle=%0d exp_cycle=%0d", c, 2 + 3 * n); end
        n++;
      end
    end
    m1_req = 1'b0;
    checks++; if (n != 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", n); end
    m0_addr = 19'h00010; m0_req = 1'b1; m1_req = 1'b1;
    tick();
    checks++; if (bus_address !== 19'h00010) begin errors++; $display("FAIL b2b_tie got_addr=%h exp=00010", bus_address); end
    tick();
    checks++; if (m0_ack !== 1'b1) begin errors++; $display("FAIL b2b_tie_ack got=%b exp=1", m0_ack); end
    m0_req = 1'b0;
    tick();
    tick();
    checks++; if (bus_address !== 19'h00020) begin errors++; $display("FAIL b2b_then_m1 got_addr=%h exp=00020", bus_address); end
    tick();
    checks++; if (m1_ack !== 1'b1) begin errors++; $display("FAIL b2b_then_m1_ack got=%b exp=1", m1_ack); end
    m1_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_issue();
    m0_addr = 19'h05c00; m0_write = 1'b1; m0_wdata = 8'h11; m0_req = 1'b1;
    tick();
    checks++; if (bus_write_en !== 1'b1 || bus_data_out !== 8'h11) begin errors++; $display("FAIL rst_issue_bus got=%b/%h exp=1/11", bus_write_en, bus_data_out); end
    reset = 1'b1;
    tick();
    checks++; if (leds !== 8'h11) begin errors++; $display("FAIL rst_issue_leds got=%h exp=11", leds); end
    checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin errors++; $display("FAIL rst_issue_ack got=%b%b exp=00", m0_ack, m1_ack); end
    checks++; if (bus_write_en !== 1'b0 || bus_address !== 19'h0 || bus_data_out !== 8'h00) begin errors++; $display("FAIL rst_issue_bus_clr got=%b/%h/%h exp=0/0/00", bus_write_en, bus_address, bus_data_out); end
    checks++; if (m0_rdata !== 8'h00 || m1_rdata !== 8'h00) begin errors++; $display("FAIL rst_issue_rdata got=%h/%h exp=00/00", m0_rdata, m1_rdata); end
    m0_req = 1'b0; reset = 1'b0;
    m1_addr = 19'h01066; m1_write = 1'b0; m1_req = 1'b1;
    tick();
    checks++; if (bus_address !== 19'h01066) begin errors++; $display("FAIL rst_idle_grant got_addr=%h exp=01066", bus_address); end
    tick();
    checks++; if (m1_ack !== 1'b1 || m1_rdata !== 8'hC3) begin errors++; $display("FAIL rst_idle_ack got=%b/%h exp=1/c3", m1_ack, m1_rdata); end
    m1_req = 1'b0;
    tick();
  endtask

  task automatic test_serialize();
    int m0_at;
    int m1_at;
    int we_cycles;
    logic prev_we;
    m0_at = -1; m1_at = -1; we_cycles = 0; prev_we = 1'b0;
    m0_addr = 19'h05c00; m0_write = 1'b1; m0_wdata = 8'hFF; m0_req = 1'b1;
    m1_addr = 19'h01066; m1_write = 1'b0; m1_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      checks++; if (m0_ack && m1_ack) begin errors++; $display("FAIL ser_two_acks cycle=%0d got=11 exp=at most one", c); end
      checks++; if (bus_write_en && (m0_ack || m1_ack)) begin errors++; $display("FAIL ser_we_with_ack cycle=%0d got=%b/%b%b", c, bus_write_en, m0_ack, m1_ack); end
      checks++; if (prev_we && bus_write_en) begin errors++; $display("FAIL ser_we_consecutive cycle=%0d got=11 exp=not both", c); end
      if (bus_write_en) we_cycles++;
      prev_we = bus_write_en;
      if (m0_ack) begin m0_at = c; m0_req = 1'b0; end
      if (m1_ack) begin m1_at = c; m1_req = 1'b0; end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    checks++; if (m0_at != 2 || m1_at != 5) begin errors++; $display("FAIL ser_order got=m0@%0d m1@%0d exp=m0@2 m1@5", m0_at, m1_at); end
    checks++; if (we_cycles != 1) begin errors++; $display("FAIL ser_we_count got=%0d exp=1", we_cycles); end
    checks++; if (leds !== 8'hFF || m1_rdata !== 8'hC3) begin errors++; $display("FAIL ser_data got=%h/%h exp=ff/c3", leds, m1_rdata); end
  endtask

  initial begin
    errors = 0; checks = 0;
    leds = 8'h3C;
    reset = 1'b1;
    m0_req = 1'b0; m0_addr = '0; m0_write = 1'b0; m0_wdata = '0;
    m1_req = 1'b0; m1_addr = '0; m1_write = 1'b0; m1_wdata = '0;
    test_reset();
    test_m0_write();
    test_m1_read();
    test_arbitration();
    test_back_to_back();
    test_reset_in_issue();
    test_serialize();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
